// File: rtl/sr_cmd_gen_pkg.sv
// Shared types and helpers for the SR latch command generator.
package sr_cmd_pkg;

   // Command FSM states; outputs are decoded directly from this encoding.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE_S = 2'd1,
      PULSE_R = 2'd2,
      GAP     = 2'd3
   } sr_state_t;

   // Bits needed to hold the value n. A zero-width vector is illegal, so
   // a parameter of 0 still gets one bit.
   function automatic int cnt_w(input int n);
      cnt_w = (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sr_cmd_gen_sync_debounce.sv
// Two-flop synchroniser, debounce filter and rising-edge detector for one
// raw push-button input.
module sync_debounce
   import sr_cmd_pkg::*;
#(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise
);

   if (DB_CYCLES < 1) begin : g_bad_db_cycles
      $error("sync_debounce: DB_CYCLES must be >= 1");
   end

   localparam int CW = cnt_w(DB_CYCLES);
   // The counter never reaches DB_CYCLES: the cycle that would take it there
   // flips the level and clears the counter instead.
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          level_dly_q;

   // Synchroniser chain: sync_q[1] is the first metastability-safe sample.
   // NOTE: every clocked register uses <= so all flops update from the
   // pre-edge values; blocking = here would collapse the two-flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], din};
      end
   end

   // Debounce rule: count consecutive cycles where the input disagrees with
   // the filtered level; flip the level once the disagreement has lasted
   // DB_CYCLES cycles. Any agreement restarts the count.
   // NOTE: the defaults at the top give every path an assignment, so no
   // latch is inferred for cnt_d or level_d.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_q[1] != level_q) begin
         if (cnt_q == DB_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Filtered level, its one-cycle delay for edge detection, and the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
      end
   end

   assign level = level_q;
   // Rise is decoded from registers only, high for one cycle after the level
   // goes from 0 to 1. Falling edges produce nothing.
   assign rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// Command stage for a NOR SR latch: cleans two raw buttons into one-deep
// pending requests and serialises them into fixed-width, mutually exclusive
// s/r pulses with a guard gap between commands.
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int DB_CYCLES = 4,
   parameter int PULSE_W   = 2,
   parameter int GAP_W     = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_btn,
   input  logic reset_btn,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);

   if (PULSE_W < 1) begin : g_bad_pulse_w
      $error("sr_cmd_gen: PULSE_W must be >= 1");
   end
   if (GAP_W < 0) begin : g_bad_gap_w
      $error("sr_cmd_gen: GAP_W must be >= 0");
   end

   // One counter times both the pulse and the gap, so it is sized for the
   // larger of the two.
   localparam int CNT_W = (cnt_w(PULSE_W) > cnt_w(GAP_W)) ? cnt_w(PULSE_W)
                                                          : cnt_w(GAP_W);
   localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PULSE_W - 1);
   // With GAP_W == 0 the GAP state is never entered; the value is unused.
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_W > 0) ? GAP_W - 1 : 0);

   logic set_rise, reset_rise;
   logic set_level_unused, reset_level_unused;

   sr_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_s_q, pend_s_d;
   logic             pend_r_q, pend_r_d;

   sync_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_set_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (set_btn),
      .level (set_level_unused),
      .rise  (set_rise)
   );

   sync_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_reset_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (reset_btn),
      .level (reset_level_unused),
      .rise  (reset_rise)
   );

   // State register: FSM state, pulse/gap timer and the pending flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pend_s_q <= 1'b0;
         pend_r_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_s_q <= pend_s_d;
         pend_r_q <= pend_r_d;
      end
   end

   // Next state: IDLE consumes every pending request (reset wins and a
   // simultaneous set is dropped); pulses and gaps run for fixed counts.
   // A rise in the same cycle as acceptance is kept as a fresh request.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_s_d = pend_s_q | set_rise;
      pend_r_d = pend_r_q | reset_rise;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pend_r_q) begin
               state_d  = PULSE_R;
               pend_r_d = reset_rise;
               pend_s_d = set_rise;
            end else if (pend_s_q) begin
               state_d  = PULSE_S;
               pend_s_d = set_rise;
            end
         end
         PULSE_S, PULSE_R: begin
            if (cnt_q == PW_LAST) begin
               cnt_d   = '0;
               state_d = (GAP_W == 0) ? IDLE : GAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only, so s and r are one-hot
   // by construction and carry no path from the buttons.
   always_comb begin
      s        = (state_q == PULSE_S);
      r        = (state_q == PULSE_R);
      busy     = (state_q != IDLE);
      conflict = (state_q == IDLE) & pend_s_q & pend_r_q;
   end

endmodule
